// File: rtl/lcd_pattern_pkg.sv
// Shared definitions for the LCD pattern generator: mode encodings, RGB565 bar colours
// and small helpers used by the pattern mux.
package lcd_pattern_pkg;

   typedef enum logic [1:0] {
      PAT_VBAR   = 2'd0,
      PAT_HBAR   = 2'd1,
      PAT_CHECK  = 2'd2,
      PAT_SCROLL = 2'd3
   } pat_mode_t;

   localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_BLUE    = 16'h001F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = RGB_WHITE;
         3'd1:    c = RGB_YELLOW;
         3'd2:    c = RGB_CYAN;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_MAGENTA;
         3'd5:    c = RGB_RED;
         3'd6:    c = RGB_BLUE;
         default: c = RGB_BLACK;
      endcase
      return c;
   endfunction

   // Remainder pixels past the eighth bar stay on the last (black) bar.
   function automatic logic [2:0] sat_bar(input logic [15:0] q);
      return (q > 16'd7) ? 3'd7 : q[2:0];
   endfunction

endpackage

// File: rtl/lcd_pattern_timing_gen_core.sv
// LCD raster timing: h/v counters, registered DE/HSYNC/VSYNC/frame_start, and the
// raw pixel coordinates for the pattern logic in the parent.
module lcd_timing_core #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 210,
   parameter int H_SYNC   = 4,
   parameter int H_BP     = 42,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 22,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 10,
   parameter bit SYNC_POL = 1'b0,
   parameter int HW       = 11,
   parameter int VW       = 10
) (
   input  logic          clk,
   input  logic          Reset_Button,
   output logic [HW-1:0] x,
   output logic [VW-1:0] y,
   output logic          active,
   output logic          frame_origin,
   output logic          frame_wrap,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          SYNC_IDLE = ~SYNC_POL;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          line_end;
   logic          hs_act;
   logic          vs_act;

   assign line_end     = (h_cnt == H_LAST);
   assign frame_wrap   = line_end && (v_cnt == V_LAST);
   assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
   assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_act       = (h_cnt >= H_SS) && (h_cnt < H_SE);
   assign vs_act       = (v_cnt >= V_SS) && (v_cnt < V_SE);
   assign x            = h_cnt;
   assign y            = v_cnt;

   always_ff @(posedge clk) begin
      if (Reset_Button) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_end) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Timing outputs are registered so they line up with the registered RGB in the parent.
   always_ff @(posedge clk) begin
      if (Reset_Button) begin
         de          <= 1'b0;
         hsync       <= SYNC_IDLE;
         vsync       <= SYNC_IDLE;
         frame_start <= 1'b0;
      end else begin
         de          <= active;
         hsync       <= hs_act ? SYNC_POL : SYNC_IDLE;
         vsync       <= vs_act ? SYNC_POL : SYNC_IDLE;
         frame_start <= frame_origin;
      end
   end

endmodule

// File: rtl/lcd_pattern_timing_gen.sv
// RGB565 LCD timing generator with frame-synchronous test-pattern selection.
// Optional white border overlay when LCD_PATTERN_BORDER_EN is defined.
module lcd_pattern_timing_gen
   import lcd_pattern_pkg::*;
#(
   parameter int H_ACTIVE    = 800,
   parameter int H_FP        = 210,
   parameter int H_SYNC      = 4,
   parameter int H_BP        = 42,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 22,
   parameter int V_SYNC      = 4,
   parameter int V_BP        = 10,
   parameter bit SYNC_POL    = 1'b0,
   parameter int CHK_LOG2    = 5,
   parameter int SCROLL_STEP = 2
) (
   input  logic        PixelClk,
   input  logic        RST,
   input  logic [1:0]  pattern_sel,
   output logic        LCD_DE,
   output logic        LCD_HSYNC,
   output logic        LCD_VSYNC,
   output logic [4:0]  LCD_R,
   output logic [5:0]  LCD_G,
   output logic [4:0]  LCD_B,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW:0]   H_ACT_W = (HW+1)'(H_ACTIVE);
   localparam logic [HW:0]   STEP_W  = (HW+1)'(SCROLL_STEP);
   localparam logic [HW-1:0] H_BAR   = HW'(H_ACTIVE / 8);
   localparam logic [VW-1:0] V_BAR   = VW'(V_ACTIVE / 8);
`ifdef LCD_PATTERN_BORDER_EN
   localparam logic [HW-1:0] X_LAST  = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] Y_LAST  = VW'(V_ACTIVE - 1);
`endif

   logic [HW-1:0] x;
   logic [VW-1:0] y;
   logic          active;
   logic          frame_origin;
   logic          frame_wrap;
   pat_mode_t     mode_q;
   pat_mode_t     mode_eff;
   logic [HW-1:0] scroll_off;
   logic [HW-1:0] off_next;
   logic [HW:0]   off_sum;
   logic [HW:0]   xs_sum;
   logic [HW-1:0] xs;
   logic [15:0]   pix_rgb;
   logic [15:0]   rgb_q;

   lcd_timing_core #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL),
      .HW       (HW),
      .VW       (VW)
   ) u_core (
      .clk          (PixelClk),
      .Reset_Button (RST),
      .x            (x),
      .y            (y),
      .active       (active),
      .frame_origin (frame_origin),
      .frame_wrap   (frame_wrap),
      .de           (LCD_DE),
      .hsync        (LCD_HSYNC),
      .vsync        (LCD_VSYNC),
      .frame_start  (frame_start)
   );

   // At the frame origin the live selection is used directly, so the whole frame
   // (including pixel 0,0) is drawn in the newly latched mode.
   assign mode_eff = frame_origin ? pat_mode_t'(pattern_sel) : mode_q;

   // Scroll offset tracks frame_cnt*SCROLL_STEP mod H_ACTIVE by accumulation.
   always_comb begin
      off_sum  = {1'b0, scroll_off} + STEP_W;
      off_next = (off_sum >= H_ACT_W) ? HW'(off_sum - H_ACT_W) : off_sum[HW-1:0];
   end

   always_comb begin
      pix_rgb = RGB_BLACK;
      xs_sum  = {1'b0, x} + {1'b0, scroll_off};
      xs      = (xs_sum >= H_ACT_W) ? HW'(xs_sum - H_ACT_W) : xs_sum[HW-1:0];
      case (mode_eff)
         PAT_VBAR:  pix_rgb = bar_rgb(sat_bar(16'(x / H_BAR)));
         PAT_HBAR:  pix_rgb = bar_rgb(sat_bar(16'(y / V_BAR)));
         PAT_CHECK: pix_rgb = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK;
         default:   pix_rgb = bar_rgb(sat_bar(16'(xs / H_BAR)));
      endcase
`ifdef LCD_PATTERN_BORDER_EN
      if ((x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST))
         pix_rgb = RGB_WHITE;
`endif
   end

   always_ff @(posedge PixelClk) begin
      if (RST) begin
         mode_q     <= PAT_VBAR;
         scroll_off <= '0;
         frame_cnt  <= '0;
         rgb_q      <= RGB_BLACK;
      end else begin
         if (frame_origin)
            mode_q <= mode_eff;
         if (frame_wrap) begin
            frame_cnt  <= frame_cnt + 16'd1;
            scroll_off <= off_next;
         end
         rgb_q <= active ? pix_rgb : RGB_BLACK;
      end
   end

   assign LCD_R = rgb_q[15:11];
   assign LCD_G = rgb_q[10:5];
   assign LCD_B = rgb_q[4:0];

endmodule

// File: tb/tb_lcd_pattern_timing_gen.sv
// Directed bench for lcd_pattern_timing_gen on a 16x8 active raster (22x11 total).
// Honours LCD_PATTERN_BORDER_EN so it can be built against either configuration.
module tb_lcd_pattern_timing_gen;

   localparam int HT = 22;
   localparam int FT = 242;

   logic        PixelClk = 1'b0;
   logic        RST;
   logic [1:0]  pattern_sel;
   logic        LCD_DE;
   logic        LCD_HSYNC;
   logic        LCD_VSYNC;
   logic [4:0]  LCD_R;
   logic [5:0]  LCD_G;
   logic [4:0]  LCD_B;
   logic        frame_start;
   logic [15:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;
   int pos;
   int frame_mode;
   int de_line0;

   logic [15:0] bar_tbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   logic [15:0] line0_tbl [16] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0,
                                   16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                                   16'hF81F, 16'hF81F, 16'hF800, 16'hF800,
                                   16'h001F, 16'h001F, 16'h0000, 16'h0000};

   lcd_pattern_timing_gen #(
      .H_ACTIVE    (16),
      .H_FP        (2),
      .H_SYNC      (2),
      .H_BP        (2),
      .V_ACTIVE    (8),
      .V_FP        (1),
      .V_SYNC      (1),
      .V_BP        (1),
      .SYNC_POL    (1'b0),
      .CHK_LOG2    (1),
      .SCROLL_STEP (2)
   ) dut (
      .PixelClk    (PixelClk),
      .RST         (RST),
      .pattern_sel (pattern_sel),
      .LCD_DE      (LCD_DE),
      .LCD_HSYNC   (LCD_HSYNC),
      .LCD_VSYNC   (LCD_VSYNC),
      .LCD_R       (LCD_R),
      .LCD_G       (LCD_G),
      .LCD_B       (LCD_B),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt)
   );

   always #5 PixelClk = ~PixelClk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @pos %0d: got %h expected %h", tag, pos, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_rgb(input int m, input int h, input int v, input int n);
      int xs;
      if (h >= 16 || v >= 8) return 16'h0000;
`ifdef LCD_PATTERN_BORDER_EN
      if (h == 0 || h == 15 || v == 0 || v == 7) return 16'hFFFF;
`endif
      case (m)
         0:       return bar_tbl[h / 2];
         1:       return bar_tbl[v];
         2:       return ((((h >> 1) ^ (v >> 1)) & 1) != 0) ? 16'hFFFF : 16'h0000;
         default: begin
            xs = (h + 2 * n) % 16;
            return bar_tbl[xs / 2];
         end
      endcase
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_de"}, {31'd0, LCD_DE}, 32'd0);
      check({tag, "_hsync"}, {31'd0, LCD_HSYNC}, 32'd1);
      check({tag, "_vsync"}, {31'd0, LCD_VSYNC}, 32'd1);
      check({tag, "_rgb"}, {16'd0, LCD_R, LCD_G, LCD_B}, 32'd0);
      check({tag, "_fstart"}, {31'd0, frame_start}, 32'd0);
      check({tag, "_fcnt"}, {16'd0, frame_cnt}, 32'd0);
   endtask

   task automatic check_pixel();
      int f, h, v, fi;
      logic [15:0] rgb;
      f   = pos % FT;
      h   = f % HT;
      v   = f / HT;
      fi  = pos / FT;
      rgb = {LCD_R, LCD_G, LCD_B};
      check("de", {31'd0, LCD_DE}, (h < 16 && v < 8) ? 32'd1 : 32'd0);
      check("hsync", {31'd0, LCD_HSYNC}, (h == 18 || h == 19) ? 32'd0 : 32'd1);
      check("vsync", {31'd0, LCD_VSYNC}, (v == 9) ? 32'd0 : 32'd1);
      check("frame_start", {31'd0, frame_start}, (f == 0) ? 32'd1 : 32'd0);
      check("frame_cnt", {16'd0, frame_cnt}, 32'((pos + 1) / FT));
      check("rgb", {16'd0, rgb}, {16'd0, exp_rgb(frame_mode, h, v, fi)});
      if (pos < HT && LCD_DE) de_line0++;
`ifndef LCD_PATTERN_BORDER_EN
      if (fi == 0 && v == 0 && h < 16) check("line0_bars", {16'd0, rgb}, {16'd0, line0_tbl[h]});
      if (frame_mode == 2 && v == 0 && h == 0) check("chk_0_0", {16'd0, rgb}, 32'h0000);
`else
      if (v == 4 && (h == 0 || h == 15)) check("border", {16'd0, rgb}, 32'hFFFF);
`endif
      if (frame_mode == 2 && v == 0 && h == 2) check("chk_2_0", {16'd0, rgb}, 32'hFFFF);
      if (frame_mode == 2 && v == 2 && h == 2) check("chk_2_2", {16'd0, rgb}, 32'h0000);
      if (frame_mode == 3 && v == 1 && h == 1) check("scroll_x1", {16'd0, rgb}, {16'd0, bar_tbl[fi % 8]});
   endtask

   task automatic run_pixels(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge PixelClk);
         pos++;
         if (pos % FT == 0) frame_mode = int'(pattern_sel);
         check_pixel();
      end
   endtask

   initial begin
      RST         = 1'b1;
      pattern_sel = 2'd0;
      pos         = -1;
      frame_mode  = 0;
      de_line0    = 0;
      repeat (3) begin
         @(negedge PixelClk);
         check_reset("reset");
      end
      RST = 1'b0;

      run_pixels(80);
      check("de_per_line", 32'(de_line0), 32'd16);

      pattern_sel = 2'd2;
      run_pixels(262);
      pattern_sel = 2'd1;
      run_pixels(243);
      pattern_sel = 2'd3;
      run_pixels(2974 - 584);

      RST = 1'b1;
      @(negedge PixelClk);
      check_reset("midreset");
      RST = 1'b0;
      pos = -1;
      run_pixels(243);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
